// File: rtl/tone_arbiter.sv
// Round-robin owner arbitration for the shared tone_generator: one source at a time,
// time-quantum preemption when others wait, and a silent gap between owners.
module tone_arbiter #(
    parameter int MAX_HOLD_CYCLES = 125_000_000,
    parameter int GAP_CYCLES      = 1_250_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [23:0] tone0,
    input  logic [23:0] tone1,
    input  logic [23:0] tone2,
    output logic [2:0]  grant,
    output logic [23:0] tone_out,
    output logic        tone_en,
    output logic        busy
);

    localparam int HW = $clog2(MAX_HOLD_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD_CYCLES);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [23:0]   tone_q, tone_d;
    logic          en_q, en_d;
    logic          busy_q, busy_d;
    logic [1:0]    last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [GW-1:0] gap_q, gap_d;

    function automatic logic [23:0] tone_sel(input logic [1:0] idx,
                                             input logic [23:0] t0,
                                             input logic [23:0] t1,
                                             input logic [23:0] t2);
        case (idx)
            2'd0:    return t0;
            2'd1:    return t1;
            2'd2:    return t2;
            default: return 24'd0;
        endcase
    endfunction

    // Round-robin candidates: the two sources after last owner, then last owner itself.
    logic [1:0] cand1, cand2;
    logic       win_vld;
    logic [1:0] win_idx;

    always_comb begin
        cand1   = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        cand2   = (last_q == 2'd0) ? 2'd2 : last_q - 2'd1;
        win_vld = 1'b1;
        win_idx = last_q;
        if (req[cand1]) begin
            win_idx = cand1;
        end else if (req[cand2]) begin
            win_idx = cand2;
        end else if (req[last_q]) begin
            win_idx = last_q;
        end else begin
            win_vld = 1'b0;
        end
    end

    logic others_req;
    logic do_arb;

    assign others_req = |(req & ~grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        tone_d  = tone_q;
        en_d    = en_q;
        last_d  = last_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        do_arb  = 1'b0;

        case (state_q)
            S_IDLE: begin
                do_arb = 1'b1;
            end
            S_OWN: begin
                // Release and quantum expiry collapse into one transition to GAP.
                if (!req[last_q] || (hold_q == HOLD_MAX && others_req)) begin
                    state_d = S_GAP;
                    grant_d = 3'b000;
                    tone_d  = 24'd0;
                    en_d    = 1'b0;
                    gap_d   = GAP_LOAD;
                end else begin
                    tone_d = tone_sel(last_q, tone0, tone1, tone2);
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q - GW'(1);
                if (gap_q == GW'(1)) begin
                    do_arb = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 3'b000;
                tone_d  = 24'd0;
                en_d    = 1'b0;
            end
        endcase

        if (do_arb) begin
            if (win_vld) begin
                state_d = S_OWN;
                grant_d = 3'b001 << win_idx;
                tone_d  = tone_sel(win_idx, tone0, tone1, tone2);
                en_d    = 1'b1;
                hold_d  = HW'(1);
                last_d  = win_idx;
            end else begin
                state_d = S_IDLE;
                grant_d = 3'b000;
                tone_d  = 24'd0;
                en_d    = 1'b0;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= 3'b000;
            tone_q  <= 24'd0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 2'd2;
            hold_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            tone_q  <= tone_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
        end
    end

    assign grant    = grant_q;
    assign tone_out = tone_q;
    assign tone_en  = en_q;
    assign busy     = busy_q;

endmodule

// File: doc/tone_arbiter.md
# tone_arbiter

Shares the single tone_generator between three tone sources: music_streamer, a live-play source and a test-tone source. Requesters assert a level request with a 24-bit tone period. The block grants one owner at a time by round-robin, enforces a time quantum when other requesters are waiting, and inserts a silent gap between owners. It drives the tone_generator's tone_switch_period and output_enable inputs.

## Interface
- MAX_HOLD_CYCLES, 125_000_000: guaranteed grant length (1 s) before a waiting requester can preempt; must be ≥ 1
- GAP_CYCLES, 1_250_000: silent cycles (10 ms) between successive owners; must be ≥ 1
- clk  input  1  system clock, 125 MHz
- rst  input  1  synchronous, active-high reset
- req  input  3  level request per source; bit 0 = streamer, 1 = live, 2 = test
- tone0 / tone1 / tone2  input  24 each  requested tone_switch_period per source; 0 = rest
- grant  output  3  one-hot current owner, registered; 0 when no owner
- tone_out  output  24  registered period to tone_generator; 0 when no owner
- tone_en  output  1  registered; high exactly while grant != 0; drives output_enable
- busy  output  1  high in OWN or GAP

## Operation
- States are IDLE, OWN and GAP. Internal registers: last_owner (2b), hold_cnt (saturating, $clog2(MAX_HOLD_CYCLES+1) bits) and gap_cnt ($clog2(GAP_CYCLES+1) bits).
- Arbitration runs at any edge in IDLE, and at the final edge of GAP.
  - Search order is last_owner+1, last_owner+2, last_owner (mod 3). The first index with req high wins.
  - If there is a winner: go to OWN, set grant to the one-hot winner, load tone_out from tone[winner], set tone_en=1, set hold_cnt=1, set last_owner=winner.
  - If there is no winner: go to or stay in IDLE with all outputs 0.
- OWN:
  - Each edge, tone_out <= tone[owner], so tone changes are followed with 1-cycle latency.
  - hold_cnt increments each edge and saturates at MAX_HOLD_CYCLES.
  - Voluntary release: req[owner] sampled low → go to GAP.
  - Preemption: hold_cnt == MAX_HOLD_CYCLES and any other req bit high → go to GAP. The owner is not notified; it must keep req high to be re-served later.
  - Release and preemption in the same cycle are both treated as a transition to GAP.
  - On entry to GAP: grant=0, tone_out=0, tone_en=0, gap_cnt=GAP_CYCLES.
- GAP:
  - gap_cnt decrements each edge. The edge where gap_cnt==1 performs arbitration.
  - A request raised and dropped entirely within GAP is never granted.
- A tone value of 0 is passed through unchanged while owned; tone_en stays high.
- rst:
  - Forces IDLE; grant, tone_out, tone_en and busy all 0.
  - Sets last_owner=2, so the first search order is 0,1,2.
  - Clears hold_cnt and gap_cnt.
  - Reset takes priority over every other event, including mid-OWN and mid-GAP.

## Timing
- Request to grant: req high before edge E in IDLE → grant, tone_out and tone_en valid after E (1 cycle).
- Release to silence: req[owner] low before edge E → grant, tone_out and tone_en are 0 after E.
- Gap length: from a release or preempt at edge E, outputs stay 0 for exactly GAP_CYCLES cycles. The next grant can appear after edge E+GAP_CYCLES.
- Contested owner: grant stays high for exactly MAX_HOLD_CYCLES cycles when another req is already waiting. Uncontested, it is held indefinitely.
- busy: follows state with no extra latency (registered alongside the state).
- Invariant: grant is always one-hot or zero.
- Invariant: tone_en == |grant.

## Test plan
(MAX_HOLD_CYCLES=8, GAP_CYCLES=3 for all scenarios)
- Reset then req=3'b001, tone0=24'd1000 → grant=001, tone_out=1000, tone_en=1 one cycle later. Change tone0 to 2000 → tone_out=2000 one cycle later. Drop req → outputs 0 next cycle, busy high for 3 cycles, then IDLE.
- Reset, req=3'b111 constantly with distinct tones → grant sequence 001,010,100,001. Each grant lasts 8 cycles, separated by 3 cycles of grant=0 with tone_out=0.
- Owner 1 granted alone for 20 cycles, then req[2] rises → grant 010 drops after the edge following req[2] high (hold saturated). Grant=100 appears 3 cycles later.
- In GAP, req[0] pulses for 2 cycles and req[1] stays low → no grant; state IDLE after the gap.
- Assert rst mid-OWN (grant=100) and mid-GAP → all outputs 0 next cycle. With req=3'b110 held, the first grant after reset is 010.
- Owner drops req on the same cycle hold reaches 8 with another req pending → a single transition to GAP, exactly 3 gap cycles, then the next requester is granted.
